// File: rtl/hazard_pkg.sv
// Shared types and default widths for the pipeline hazard control unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    HCU_RUN      = 2'd0,
    HCU_MEM_WAIT = 2'd1,
    HCU_FAULT    = 2'd2
  } hcu_state_t;

  localparam int HCU_RA_WIDTH    = 5;
  localparam int HCU_MEM_TIMEOUT = 255;
  localparam int HCU_CNT_WIDTH   = 32;

  // Pipeline-register advance enables, oldest-to-youngest order reversed (PC first).
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } hcu_en_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic memwb;
  } hcu_flush_t;

endpackage

// File: rtl/hcu_sat_counter.sv
// Saturating up-counter; clr restarts the count and a simultaneous inc counts that cycle.
module hcu_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    // NOTE: assign a default first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? WIDTH'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage core: load-use, redirect, fetch and dmem-wait
// hazards, a dmem-wait watchdog and a saturating stall-cycle counter.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REGFILE_ADDR_WIDTH = HCU_RA_WIDTH,
  parameter int MEM_TIMEOUT        = HCU_MEM_TIMEOUT,
  parameter int CNT_WIDTH          = HCU_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_address,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_address,
  input  logic                          ID_uses_rs1,
  input  logic                          ID_uses_rs2,
  input  logic                          EX_MemRead,
  input  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_address,
  input  logic                          EX_redirect,
  input  logic                          IF_imem_ready,
  input  logic                          MEM_dmem_req,
  input  logic                          MEM_dmem_ready,
  output logic                          PC_en,
  output logic                          IFID_en,
  output logic                          IDEX_en,
  output logic                          EXMEM_en,
  output logic                          MEMWB_en,
  output logic                          IFID_flush,
  output logic                          IDEX_flush,
  output logic                          MEMWB_flush,
  output logic                          dmem_fault,
  output logic [CNT_WIDTH-1:0]          stall_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hcu_state_t       state_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic             dmem_stall;
  logic             freeze;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             load_use;
  logic             wait_inc;
  logic             stall_inc;
  hcu_en_t          en;
  hcu_flush_t       fl;

  assign dmem_stall = MEM_dmem_req & ~MEM_dmem_ready;
  assign freeze     = dmem_stall | (state_q == HCU_FAULT);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rs1_hit  = ID_uses_rs1 & (ID_Rs1_address == EX_Rd_address);
  assign rs2_hit  = ID_uses_rs2 & (ID_Rs2_address == EX_Rd_address);
  assign load_use = EX_MemRead & (EX_Rd_address != '0) & (rs1_hit | rs2_hit);

  always_comb begin
    en = '1;
    fl = '0;
    if (rst) begin
      en = '0;
      fl = '1;
    end else if (freeze) begin
      // The held EX instruction re-presents any redirect once the freeze lifts.
      en       = '0;
      fl.memwb = 1'b1;
    end else if (EX_redirect) begin
      fl.ifid = 1'b1;
      fl.idex = 1'b1;
    end else if (load_use) begin
      en.pc   = 1'b0;
      en.ifid = 1'b0;
      fl.idex = 1'b1;
    end else if (!IF_imem_ready) begin
      en.pc   = 1'b0;
      fl.ifid = 1'b1;
    end
  end

  assign PC_en       = en.pc;
  assign IFID_en     = en.ifid;
  assign IDEX_en     = en.idex;
  assign EXMEM_en    = en.exmem;
  assign MEMWB_en    = en.memwb;
  assign IFID_flush  = fl.ifid;
  assign IDEX_flush  = fl.idex;
  assign MEMWB_flush = fl.memwb;
  assign dmem_fault  = (state_q == HCU_FAULT) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HCU_RUN;
    end else begin
      case (state_q)
        HCU_RUN: begin
          if (dmem_stall) state_q <= HCU_MEM_WAIT;
        end
        HCU_MEM_WAIT: begin
          if (!dmem_stall) begin
            state_q <= HCU_RUN;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state_q <= HCU_FAULT;
          end
        end
        HCU_FAULT: state_q <= HCU_FAULT;
        default:   state_q <= HCU_RUN;
      endcase
    end
  end

  // wait_cnt holds the number of consecutive dmem-stall cycles already elapsed.
  assign wait_inc = dmem_stall & (state_q != HCU_FAULT);

  hcu_sat_counter #(
    .WIDTH (WAIT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (wait_inc),
    .clr_i   (~wait_inc),
    .count_o (wait_cnt)
  );

  assign stall_inc = ~en.pc & ~rst;

  hcu_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_inc),
    .clr_i   (1'b0),
    .count_o (stall_cycles)
  );

endmodule
